// File: rtl/gb_clkgen_pkg.sv
// Shared types and constants for the DMG clock generator / trigger capture block.
package gb_clkgen_pkg;

  localparam int unsigned MODE_W = 2;
  localparam int unsigned STOP_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_FREE  = 2'd0,
    MODE_ALIGN = 2'd1,
    MODE_COUNT = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_st_e;

  // Why running drops in a given cycle; STOP_NONE means keep or start.
  localparam logic [STOP_W-1:0] STOP_NONE  = 2'd0;
  localparam logic [STOP_W-1:0] STOP_USER  = 2'd1;
  localparam logic [STOP_W-1:0] STOP_ALIGN = 2'd2;
  localparam logic [STOP_W-1:0] STOP_COUNT = 2'd3;

endpackage

// File: rtl/gb_clkgen_trig_if.sv
// Registered DMG bus as seen by the trigger comparators.
interface gb_clkgen_trig_if #(
  parameter int unsigned ADR_WIDTH = 16
);
  logic [ADR_WIDTH-1:0] adr;
  logic                 n_rd;
  logic                 n_wr;

  modport master (output adr, n_rd, n_wr);
  modport slave  (input  adr, n_rd, n_wr);
endinterface

// File: rtl/gb_trig_ch.sv
// One trigger channel: address/mask/type comparator with a sticky first-hit capture.
module gb_trig_ch #(
  parameter int unsigned ADR_WIDTH = 16,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 tick_c,
  input  logic [CNT_WIDTH-1:0] count,
  input  logic [ADR_WIDTH-1:0] adr,
  input  logic                 n_rd,
  input  logic                 n_wr,
  input  logic [ADR_WIDTH-1:0] ch_adr,
  input  logic [ADR_WIDTH-1:0] ch_mask,
  input  logic                 ch_rd,
  input  logic                 ch_wr,
  output logic                 hit,
  output logic [CNT_WIDTH-1:0] at
);

  logic                 hit_q, hit_d;
  logic [CNT_WIDTH-1:0] at_q, at_d;
  logic                 match_c;

  always_comb begin
    hit_d   = hit_q;
    at_d    = at_q;
    match_c = !hit_q
            && (((adr ^ ch_adr) & ch_mask) == '0)
            && ((ch_rd && !n_rd) || (ch_wr && !n_wr));
    if (clear) begin
      hit_d = 1'b0;
      at_d  = '0;
    end else if (tick_c && match_c) begin
      hit_d = 1'b1;
      at_d  = count;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q <= 1'b0;
      at_q  <= '0;
    end else begin
      hit_q <= hit_d;
      at_q  <= at_d;
    end
  end

  assign hit = hit_q;
  assign at  = at_q;

endmodule

// File: rtl/gb_clkgen_trig.sv
// DMG X1 clock divider with tick counter, run control (free/align/count stop)
// and NCH first-access capture channels.
module gb_clkgen_trig
  import gb_clkgen_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 4,
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned NCH       = 4,
  parameter int unsigned ADR_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     clear,
  input  logic [MODE_W-1:0]        mode,
  input  logic [1:0]               align,
  input  logic [CNT_WIDTH-1:0]     stop_cnt,
  gb_clkgen_trig_if.slave          bus,
  input  logic [NCH*ADR_WIDTH-1:0] ch_adr,
  input  logic [NCH*ADR_WIDTH-1:0] ch_mask,
  input  logic [NCH-1:0]           ch_rd,
  input  logic [NCH-1:0]           ch_wr,
  output logic                     clkout,
  output logic                     tick,
  output logic                     running,
  output logic [CNT_WIDTH-1:0]     count,
  output logic [NCH-1:0]           ch_hit,
  output logic [NCH*CNT_WIDTH-1:0] ch_at
);

  run_st_e              state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 tick_q, tick_d;
  logic                 tick_c;
  logic [STOP_W-1:0]    stop_why_c;
  mode_e                mode_c;

  // Next-state: divider, tick detect, counter, stop arbitration; clear overrides all.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    count_d    = count_q;
    tick_d     = 1'b0;
    tick_c     = 1'b0;
    stop_why_c = STOP_NONE;
    mode_c     = mode_e'(mode);

    if (state_q == ST_RUN) div_d = div_q + DIV_WIDTH'(1);
    tick_c = div_d[DIV_WIDTH-1] && !div_q[DIV_WIDTH-1];
    if (tick_c) count_d = count_q + CNT_WIDTH'(1);

    if (stop) begin
      stop_why_c = STOP_USER;
    end else if (tick_c && mode_c == MODE_ALIGN
                 && count_d[1:0] == align && count_q[1:0] != align) begin
      stop_why_c = STOP_ALIGN;
    end else if (tick_c && mode_c == MODE_COUNT
                 && stop_cnt != '0 && count_d == stop_cnt) begin
      stop_why_c = STOP_COUNT;
    end

    // Auto-stop beats a simultaneous start; start is seen again next cycle.
    if (stop_why_c != STOP_NONE) state_d = ST_IDLE;
    else if (start)              state_d = ST_RUN;
    tick_d = tick_c;

    if (clear) begin
      state_d = ST_IDLE;
      div_d   = '0;
      count_d = '0;
      tick_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign clkout  = div_q[DIV_WIDTH-1];
  assign tick    = tick_q;
  assign running = (state_q == ST_RUN);
  assign count   = count_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    gb_trig_ch #(
      .ADR_WIDTH (ADR_WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear),
      .tick_c  (tick_c),
      .count   (count_q),
      .adr     (bus.adr),
      .n_rd    (bus.n_rd),
      .n_wr    (bus.n_wr),
      .ch_adr  (ch_adr[i*ADR_WIDTH +: ADR_WIDTH]),
      .ch_mask (ch_mask[i*ADR_WIDTH +: ADR_WIDTH]),
      .ch_rd   (ch_rd[i]),
      .ch_wr   (ch_wr[i]),
      .hit     (ch_hit[i]),
      .at      (ch_at[i*CNT_WIDTH +: CNT_WIDTH])
    );
  end

endmodule

// File: tb/tb_gb_clkgen_trig.sv
// Self-checking bench for gb_clkgen_trig with DIV_WIDTH=2 (4-cycle DMG clock).
module tb_gb_clkgen_trig;

  logic         clk = 1'b0;
  logic         reset, start, stop, clear;
  logic [1:0]   mode, align;
  logic [31:0]  stop_cnt;
  logic [63:0]  ch_adr, ch_mask;
  logic [3:0]   ch_rd, ch_wr;
  logic         clkout, tick, running;
  logic [31:0]  count;
  logic [3:0]   ch_hit;
  logic [127:0] ch_at;

  gb_clkgen_trig_if #(.ADR_WIDTH(16)) bus ();

  gb_clkgen_trig #(
    .DIV_WIDTH (2),
    .CNT_WIDTH (32),
    .NCH       (4),
    .ADR_WIDTH (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .mode     (mode),
    .align    (align),
    .stop_cnt (stop_cnt),
    .bus      (bus),
    .ch_adr   (ch_adr),
    .ch_mask  (ch_mask),
    .ch_rd    (ch_rd),
    .ch_wr    (ch_wr),
    .clkout   (clkout),
    .tick     (tick),
    .running  (running),
    .count    (count),
    .ch_hit   (ch_hit),
    .ch_at    (ch_at)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        run;
    logic        ck;
    logic        tk;
    logic [31:0] cnt;
  } exp_t;

  typedef struct packed {
    logic start;
    logic stop;
    exp_t e;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[15];
  int   total = 0;
  int   bad = 0;
  int   tick_seen = 0;

  always @(negedge clk) if (tick === 1'b1) tick_seen++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic r, input logic c, input logic t, input logic [31:0] n);
    mk = {r, c, t, n};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pop the oldest expectation and compare it against the current outputs.
  task automatic sb_check(input string nm);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({nm, ".sb_empty"}, 64'(1), 64'(0));
    end else begin
      e = sbq.pop_front();
      chk({nm, ".running"}, 64'(running), 64'(e.run));
      chk({nm, ".clkout"},  64'(clkout),  64'(e.ck));
      chk({nm, ".tick"},    64'(tick),    64'(e.tk));
      chk({nm, ".count"},   64'(count),   64'(e.cnt));
    end
  endtask

  task automatic wait_cnt(input logic [31:0] n);
    int k = 0;
    while (count !== n && k < 5000) begin
      step(1);
      k++;
    end
    chk($sformatf("wait_count_%0d", n), 64'(count), 64'(n));
  endtask

  task automatic wait_stop(input string nm);
    int k = 0;
    while (running !== 1'b0 && k < 5000) begin
      step(1);
      k++;
    end
    chk({nm, ".stopped"}, 64'(running), 64'(0));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  task automatic bus_drv(input logic [15:0] a, input logic r, input logic w);
    bus.adr  = a;
    bus.n_rd = r;
    bus.n_wr = w;
  endtask

  task automatic vset(input int i, input logic st, input logic sp,
                      input logic r, input logic c, input logic t, input logic [31:0] n);
    vecs[i] = {st, sp, mk(r, c, t, n)};
  endtask

  task automatic chk_zeroed(input string nm);
    sbq.push_back(mk(1'b0, 1'b0, 1'b0, 32'd0));
    sb_check(nm);
    chk({nm, ".ch_hit"}, 64'(ch_hit), 64'(0));
    chk({nm, ".ch_at0"}, 64'(ch_at[31:0]), 64'(0));
    chk({nm, ".ch_at_all_zero"}, 64'(ch_at == '0), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Cycle-by-cycle run control and waveform after reset.
    vset(0,  0, 0, 0, 0, 0, 0);
    vset(1,  1, 0, 1, 0, 0, 0);
    vset(2,  1, 0, 1, 0, 0, 0);
    vset(3,  1, 0, 1, 1, 1, 1);
    vset(4,  1, 0, 1, 1, 0, 1);
    vset(5,  1, 0, 1, 0, 0, 1);
    vset(6,  1, 0, 1, 0, 0, 1);
    vset(7,  1, 0, 1, 1, 1, 2);
    vset(8,  0, 1, 0, 1, 0, 2);
    vset(9,  0, 0, 0, 1, 0, 2);
    vset(10, 1, 1, 0, 1, 0, 2);
    vset(11, 1, 0, 1, 1, 0, 2);
    vset(12, 0, 0, 1, 0, 0, 2);
    vset(13, 0, 0, 1, 0, 0, 2);
    vset(14, 0, 0, 1, 1, 1, 3);

    reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
    mode = 2'd0; align = 2'd0; stop_cnt = 32'd0;
    ch_adr  = {16'h0000, 16'hFF00, 16'hFF00, 16'h0100};
    ch_mask = {16'h0000, 16'hFF00, 16'hFF00, 16'hFFFF};
    ch_rd   = 4'b0001;
    ch_wr   = 4'b0110;
    bus_drv(16'h0000, 1'b1, 1'b1);
    step(3);
    chk_zeroed("reset");
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      start = vecs[i].start;
      stop  = vecs[i].stop;
      sbq.push_back(vecs[i].e);
      step(1);
      sb_check($sformatf("vec%0d", i));
    end
    start = 1'b0; stop = 1'b0;

    // Free run: 40 cycles of start yields 10 ticks.
    do_clear();
    chk_zeroed("clr0");
    start = 1'b1;
    step(40);
    start = 1'b0;
    sbq.push_back(mk(1'b1, 1'b1, 1'b0, 32'd10));
    sb_check("free40");

    // Two write channels capture the same count; a read is ignored.
    do_clear();
    pulse_start();
    wait_cnt(6);
    bus_drv(16'hFF47, 1'b0, 1'b1);
    wait_cnt(7);
    chk("rd_ignored.ch_hit", 64'(ch_hit), 64'(0));
    bus_drv(16'hFF47, 1'b1, 1'b0);
    wait_cnt(8);
    bus_drv(16'h0000, 1'b1, 1'b1);
    chk("wr_hit.ch_hit", 64'(ch_hit), 64'h6);
    chk("wr_hit.ch_at1", 64'(ch_at[63:32]), 64'd7);
    chk("wr_hit.ch_at2", 64'(ch_at[95:64]), 64'd7);

    // First read match at old count 299 is kept; a later match is ignored.
    wait_cnt(299);
    bus_drv(16'h0100, 1'b0, 1'b1);
    wait_cnt(300);
    bus_drv(16'h0000, 1'b1, 1'b1);
    chk("rd_hit.ch_hit", 64'(ch_hit), 64'h7);
    chk("rd_hit.ch_at0", 64'(ch_at[31:0]), 64'd299);
    wait_cnt(499);
    bus_drv(16'h0100, 1'b0, 1'b1);
    wait_cnt(500);
    bus_drv(16'h0000, 1'b1, 1'b1);
    chk("rd_rpt.ch_at0", 64'(ch_at[31:0]), 64'd299);
    chk("rd_rpt.ch_at1", 64'(ch_at[63:32]), 64'd7);

    // Manual stop at 13, then aligned stop (align=2) at 14 and 18.
    do_clear();
    pulse_start();
    wait_cnt(13);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    sbq.push_back(mk(1'b0, 1'b1, 1'b0, 32'd13));
    sb_check("stop13");
    step(5);
    sbq.push_back(mk(1'b0, 1'b1, 1'b0, 32'd13));
    sb_check("stop13_hold");
    mode = 2'd1; align = 2'd2;
    pulse_start();
    wait_stop("align14");
    sbq.push_back(mk(1'b0, 1'b1, 1'b1, 32'd14));
    sb_check("align14");
    pulse_start();
    wait_stop("align18");
    sbq.push_back(mk(1'b0, 1'b1, 1'b1, 32'd18));
    sb_check("align18");

    // Stop at count 5: exactly five ticks, then idle.
    mode = 2'd2; stop_cnt = 32'd5;
    do_clear();
    begin
      int t0;
      t0 = tick_seen;
      pulse_start();
      wait_stop("cnt5");
      sbq.push_back(mk(1'b0, 1'b1, 1'b1, 32'd5));
      sb_check("cnt5");
      step(8);
      sbq.push_back(mk(1'b0, 1'b1, 1'b0, 32'd5));
      sb_check("cnt5_hold");
      chk("cnt5.ticks", 64'(tick_seen - t0), 64'd5);
    end

    // start held through the stop tick: stop wins, running returns a cycle later.
    do_clear();
    start = 1'b1;
    wait_cnt(5);
    sbq.push_back(mk(1'b0, 1'b1, 1'b1, 32'd5));
    sb_check("cnt5_held");
    step(1);
    sbq.push_back(mk(1'b1, 1'b1, 1'b0, 32'd5));
    sb_check("cnt5_restart");
    start = 1'b0;

    // clear mid-run with a captured channel.
    mode = 2'd0;
    do_clear();
    pulse_start();
    wait_cnt(3);
    bus_drv(16'h0100, 1'b0, 1'b1);
    wait_cnt(4);
    bus_drv(16'h0000, 1'b1, 1'b1);
    chk("pre_clr.ch_hit", 64'(ch_hit), 64'h1);
    chk("pre_clr.ch_at0", 64'(ch_at[31:0]), 64'd3);
    wait_cnt(9);
    do_clear();
    chk_zeroed("clr_mid");
    start = 1'b1; clear = 1'b1;
    step(3);
    sbq.push_back(mk(1'b0, 1'b0, 1'b0, 32'd0));
    sb_check("clr_with_start");
    start = 1'b0; clear = 1'b0;

    // reset mid-run behaves the same as clear.
    pulse_start();
    wait_cnt(3);
    bus_drv(16'h0100, 1'b0, 1'b1);
    wait_cnt(4);
    bus_drv(16'h0000, 1'b1, 1'b1);
    chk("pre_rst.ch_hit", 64'(ch_hit), 64'h1);
    wait_cnt(9);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk_zeroed("rst_mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
